uart_port: RTL
==============

# uart_port

Byte-wide UART engine sitting between the board's serial lines and a parallel-bus controller. It serialises bytes written by the controller on a shared tri-state 8-bit data bus, deserialises incoming frames, and presents them on the same bus. Handshake: `enable_recv`, `TxD_start`, `TxD_busy`, `RxD_data_ready` and `RxD_waiting_data`. Framing is 8N1, or 8E1 when parity is compiled in.

## Interface
- `CLK_FREQ`, 11059200: clock frequency in Hz.
- `BAUD`, 115200: line rate. Tick divider `DIV = CLK_FREQ/(BAUD*16)`, integer, must be ≥ 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `data`  inout  8  shared bus. Driven by this block only while `enable_recv`=1 and `TxD_start`=0; otherwise hi-Z.
- `enable_recv`  in  1  controller permits delivery of received bytes; also grants this block the bus.
- `TxD_start`  in  1  request to transmit the byte currently on `data`.
- `TxD_busy`  out  1  transmitter occupied.
- `RxD_data_ready`  out  1  one-cycle strobe: the received byte is valid on `data`.
- `RxD_waiting_data`  out  1  receiver idle, hunting for a start bit.
- `TxD`  out  1  serial output, idle high.
- `RxD`  in  1  serial input, asynchronous.

## Operation
- **Tick generator.** Free-running counter 0..DIV-1 issues one-cycle `tick` pulses at 16×BAUD. One bit time = 16 ticks.
- **Transmitter.** States are IDLE, START, DATA (bits 0..7, LSB first), [PARITY], STOP.
  - In IDLE, `TxD_start`=1 at an edge latches `data` into the shift register and enters START.
  - Each non-IDLE state lasts 16 ticks. STOP returns to IDLE.
  - `TxD_start` is ignored outside IDLE.
  - `TxD_busy = (state != IDLE) | TxD_start`, combinational. The controller therefore never sees busy low in the cycle following its start pulse.
- **Receiver.**
  - `RxD` passes through a 2-flop synchroniser. States are HUNT, START, DATA, [PARITY], STOP.
  - HUNT→START on a synchronised low. START re-samples at tick 8: still low → DATA, high → HUNT (glitch rejected).
  - Each DATA bit is sampled at tick 8 of its bit time, LSB first.
  - STOP samples at tick 8:
    - 1 → byte copied to the holding register, `pending`=1.
    - 0 → framing error; byte discarded.
  - In both cases the receiver returns to HUNT.
  - `RxD_waiting_data` = (receiver state == HUNT).
- **Delivery.**
  - If `pending`=1 and `enable_recv`=1 at an edge: `RxD_data_ready`=1 for exactly the next cycle and `pending` clears.
  - The holding register drives `data` whenever the bus is granted.
  - If `enable_recv`=0, `pending` holds indefinitely and delivery occurs on the first edge with `enable_recv`=1.
- **Overrun.** A new frame completing while `pending`=1 overwrites the holding register; only the newest byte is delivered.
- **Simultaneous events.** Receive completion and transmit start in the same cycle are independent; both proceed.

## Timing
- **Reset values:** `TxD`=1, `RxD_data_ready`=0, `RxD_waiting_data`=1, `TxD_busy`=`TxD_start`, `data` hi-Z while `enable_recv`=0 (otherwise drives holding register = 0x00), `pending`=0. Tick counter, both FSMs and shift registers are cleared.
- **Reset mid-frame:** TX aborts with `TxD` high immediately (asynchronous). RX abandons the partial byte.
- **TX latency:** `TxD` falls at the first `tick` after the edge that samples `TxD_start`. That is ≤ DIV cycles later, and the tick counter is not restarted. A frame is 160 ticks (176 with parity).
- **RX latency:** `RxD_data_ready` pulses 1–2 cycles after the stop-bit tick-8 sample (1 cycle if `enable_recv` is already high), plus the 2-cycle synchroniser delay.
- **Back-to-back TX:** the next start may be accepted in the cycle after `TxD_busy` falls (with `TxD_start` low).

## Configuration
- `UART_PORT_PARITY_EN`
  - **Defined:** one even-parity bit is inserted after bit 7 on TX. On RX the parity bit is sampled and checked; a mismatch discards the byte exactly like a framing error (no `RxD_data_ready`).
  - **Undefined:** 8N1, no parity state in either FSM.

## Test plan
Benches use CLK_FREQ=11059200 and BAUD=115200 (DIV=6, bit time = 96 cycles).
- **Reset:** assert `rst`=0 mid-transmission of 0xA5 → `TxD`=1 at once, `TxD_busy`=0, `RxD_waiting_data`=1. Release → line stays idle.
- **TX:** drive `data`=0x5A, pulse `TxD_start` for 1 cycle with `enable_recv`=0 → `TxD_busy` high in that same cycle. Line shows 0,0,1,0,1,1,0,1,0,1 at 96 cycles per bit. `TxD_busy` falls 960 cycles (±6) after start.
- **RX + delivery:** serialise 0x3C with `enable_recv`=1 → exactly one 1-cycle `RxD_data_ready` with `data`=0x3C. `RxD_waiting_data` is low during the frame.
- **Held delivery / overrun:** `enable_recv`=0 while 0x11 then 0x22 arrive, then raise `enable_recv` → a single `RxD_data_ready` with `data`=0x22.
- **Error rejection:** a 20-cycle low glitch on `RxD` gives no byte. Frame 0x81 with stop bit 0 gives no `RxD_data_ready` and the receiver returns to HUNT. With `UART_PORT_PARITY_EN`, 0x81 sent with parity 1 is rejected.
- **Loopback echo:** tie `TxD`→`RxD` and send the string 0x41,0x42,0x00 back-to-back → three strobes with matching bytes. Bus contention never occurs: `data` is undriven whenever `enable_recv`=0.

Source files
------------

// File: rtl/uart_port_if.sv
// Controller-side handshake bundle for uart_port. The shared data bus stays a
// plain inout on the engine so the tri-state resolves at the board level.
interface uart_port_if;
  logic enable_recv;
  logic TxD_start;
  logic TxD_busy;
  logic RxD_data_ready;
  logic RxD_waiting_data;

  modport master (
    output enable_recv,
    output TxD_start,
    input  TxD_busy,
    input  RxD_data_ready,
    input  RxD_waiting_data
  );

  modport slave (
    input  enable_recv,
    input  TxD_start,
    output TxD_busy,
    output RxD_data_ready,
    output RxD_waiting_data
  );
endinterface

// File: rtl/uart_port.sv
// Byte-wide UART engine: 8N1 framing, or 8E1 when UART_PORT_PARITY_EN is defined.
// 16x oversampling tick; received bytes are presented on the shared tri-state bus.
//
// tx state  | meaning
// TX_IDLE   | line high, waiting for TxD_start
// TX_START  | start bit (low)
// TX_DATA   | data bits 0..7, LSB first
// TX_PARITY | even parity bit (parity build only)
// TX_STOP   | stop bit (high)
//
// rx state  | meaning
// RX_HUNT   | waiting for a low on the synchronised line
// RX_START  | confirming the start bit at its centre
// RX_DATA   | sampling data bits at their centres
// RX_PARITY | sampling/checking the parity bit (parity build only)
// RX_STOP   | sampling the stop bit, then back to hunt
module uart_port #(
  parameter int CLK_FREQ = 11059200,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  uart_port_if.slave  ctl,
  inout  wire  [7:0]  data,
  output logic        TxD,
  input  logic        RxD
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PORT_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_HUNT,
    RX_START,
    RX_DATA,
`ifdef UART_PORT_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  tx_state_t  tx_state_q, tx_state_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       txd_q, txd_d;

  logic       rx_s1_q, rx_s2_q;
  rx_state_t  rx_state_q, rx_state_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_done;
  logic       frame_ok;
`ifdef UART_PORT_PARITY_EN
  logic       rx_perr_q, rx_perr_d;
`endif

  logic [7:0] hold_q, hold_d;
  logic       pending_q, pending_d;
  logic       ready_q, ready_d;

  // Down-counter tick: fires on terminal count, then reloads.
  assign tick = (tick_cnt_q == '0);
  always_comb begin
    tick_cnt_d = tick ? CNT_W'(DIV - 1) : tick_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick_cnt_q <= CNT_W'(DIV - 1);
    else      tick_cnt_q <= tick_cnt_d;
  end

  // TxD is re-driven on every tick so the start bit begins at the first tick
  // after TxD_start without restarting the tick counter.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    if (tx_state_q == TX_IDLE) begin
      txd_d = 1'b1;
      if (ctl.TxD_start) begin
        tx_shift_d = data;
        tx_state_d = TX_START;
        tx_cnt_d   = 4'd15;
        tx_bit_d   = 3'd0;
      end
    end else if (tick) begin
      case (tx_state_q)
        TX_START:  txd_d = 1'b0;
        TX_DATA:   txd_d = tx_shift_q[tx_bit_q];
`ifdef UART_PORT_PARITY_EN
        TX_PARITY: txd_d = ^tx_shift_q;
`endif
        default:   txd_d = 1'b1;
      endcase
      if (tx_cnt_q != 4'd0) begin
        tx_cnt_d = tx_cnt_q - 4'd1;
      end else begin
        tx_cnt_d = 4'd15;
        case (tx_state_q)
          TX_START: tx_state_d = TX_DATA;
          TX_DATA: begin
            if (tx_bit_q == 3'd7) begin
`ifdef UART_PORT_PARITY_EN
              tx_state_d = TX_PARITY;
`else
              tx_state_d = TX_STOP;
`endif
            end else begin
              tx_bit_d = tx_bit_q + 3'd1;
            end
          end
`ifdef UART_PORT_PARITY_EN
          TX_PARITY: tx_state_d = TX_STOP;
`endif
          default:  tx_state_d = TX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

`ifdef UART_PORT_PARITY_EN
  assign frame_ok = rx_s2_q & ~rx_perr_q;
`else
  assign frame_ok = rx_s2_q;
`endif

  // Start is confirmed after 8 ticks; every later sample is 16 ticks on.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
`ifdef UART_PORT_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    if (rx_state_q == RX_HUNT) begin
      if (!rx_s2_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = 4'd7;
      end
    end else if (tick) begin
      if (rx_cnt_q != 4'd0) begin
        rx_cnt_d = rx_cnt_q - 4'd1;
      end else begin
        rx_cnt_d = 4'd15;
        case (rx_state_q)
          RX_START: begin
            if (rx_s2_q) begin
              rx_state_d = RX_HUNT;
            end else begin
              rx_state_d = RX_DATA;
              rx_bit_d   = 3'd0;
`ifdef UART_PORT_PARITY_EN
              rx_perr_d  = 1'b0;
`endif
            end
          end
          RX_DATA: begin
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
`ifdef UART_PORT_PARITY_EN
              rx_state_d = RX_PARITY;
`else
              rx_state_d = RX_STOP;
`endif
            end else begin
              rx_bit_d = rx_bit_q + 3'd1;
            end
          end
`ifdef UART_PORT_PARITY_EN
          RX_PARITY: begin
            rx_perr_d  = rx_s2_q ^ (^rx_shift_q);
            rx_state_d = RX_STOP;
          end
`endif
          default: begin
            rx_state_d = RX_HUNT;
            rx_done    = frame_ok;
          end
        endcase
      end
    end
  end

  // A delivery and a fresh completion in one cycle hand over the newest byte once.
  always_comb begin
    hold_d    = hold_q;
    pending_d = pending_q;
    ready_d   = 1'b0;
    if (pending_q && ctl.enable_recv) begin
      ready_d   = 1'b1;
      pending_d = 1'b0;
    end
    if (rx_done) begin
      hold_d    = rx_shift_q;
      pending_d = ~(pending_q & ctl.enable_recv);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_HUNT;
      rx_cnt_q   <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
`ifdef UART_PORT_PARITY_EN
      rx_perr_q  <= 1'b0;
`endif
      hold_q     <= 8'h00;
      pending_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      rx_s1_q    <= RxD;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
`ifdef UART_PORT_PARITY_EN
      rx_perr_q  <= rx_perr_d;
`endif
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      ready_q    <= ready_d;
    end
  end

  assign data                 = (ctl.enable_recv && !ctl.TxD_start) ? hold_q : 8'bz;
  assign TxD                  = txd_q;
  assign ctl.TxD_busy         = (tx_state_q != TX_IDLE) | ctl.TxD_start;
  assign ctl.RxD_data_ready   = ready_q;
  assign ctl.RxD_waiting_data = (rx_state_q == RX_HUNT);

endmodule
